// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-lane data memory: RV32I width codes,
// controller states and the access-checking / load-extension helpers.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Rejects unknown width codes, unsigned stores, misalignment and
  // addresses beyond the implemented byte range.
  function automatic logic access_fault(input logic        we,
                                        input logic [2:0]  funct3,
                                        input logic [31:0] addr,
                                        input int unsigned addr_width);
    logic f;
    f = 1'b0;
    case (funct3)
      F3_B:  f = 1'b0;
      F3_H:  f = addr[0];
      F3_W:  f = (addr[1:0] != 2'b00);
      F3_BU: f = we;
      F3_HU: f = we | addr[0];
      default: f = 1'b1;
    endcase
    if ((addr >> (addr_width + 2)) != 32'd0) f = 1'b1;
    return f;
  endfunction

  // Moves the addressed byte/halfword to bit 0 and extends it.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  offset,
                                              input logic [2:0]  funct3);
    logic [31:0] s;
    logic [31:0] r;
    s = word >> {offset, 3'b000};
    case (funct3)
      F3_B:    r = {{24{s[7]}}, s[7:0]};
      F3_H:    r = {{16{s[15]}}, s[15:0]};
      F3_BU:   r = {24'd0, s[7:0]};
      F3_HU:   r = {16'd0, s[15:0]};
      default: r = s;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_bytelane_lane_ram.sv
// Four byte-lane synchronous RAM with per-lane write enables and a
// registered read port.
module dmem_lane_ram #(
  parameter int    ADDR_WIDTH = 15,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [3:0]            we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  (* ram_style = "block" *) logic [31:0] mem [0:(2**ADDR_WIDTH)-1];

  // Lane writes and read share one edge; read returns pre-write contents.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_bytelane.sv
// RV32 load/store data memory with valid/ready request handshake,
// programmable wait states, byte-lane stores, extended loads and faults.
module dmem_bytelane
  import dmem_pkg::*;
#(
  parameter int    ADDR_WIDTH  = 15,
  parameter int    WAIT_CYCLES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault
);

  localparam logic ZERO_WAIT = (WAIT_CYCLES == 0);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        accept;

  logic        we_p0;
  logic [2:0]  f3_p0;
  logic [31:0] addr_p0;
  logic [31:0] wdata_p0;

  logic        acc_en;
  logic        acc_we;
  logic [2:0]  acc_f3;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        acc_fault;
  logic [3:0]  acc_be;
  logic [3:0]  ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic        vld_p1;
  logic        fault_p1;
  logic        we_p1;
  logic [1:0]  off_p1;
  logic [2:0]  f3_p1;

  assign req_ready = !rst && (state != S_WAIT);
  assign accept    = req_valid && req_ready;

  // ---- stage p0: request capture at the accept edge
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= req_we;
      f3_p0    <= req_funct3;
      addr_p0  <= req_addr;
      wdata_p0 <= req_wdata;
    end
  end

  // Access source: live inputs without wait states, captured ones otherwise.
  always_comb begin
    if (ZERO_WAIT) begin
      acc_en    = accept;
      acc_we    = req_we;
      acc_f3    = req_funct3;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end else begin
      acc_en    = !rst && (state == S_WAIT) && (cnt == 4'd1);
      acc_we    = we_p0;
      acc_f3    = f3_p0;
      acc_addr  = addr_p0;
      acc_wdata = wdata_p0;
    end
  end

  // Byte enables and lane-replicated store data for the access.
  always_comb begin
    acc_fault = access_fault(acc_we, acc_f3, acc_addr, ADDR_WIDTH);
    acc_be    = 4'b0000;
    ram_wdata = acc_wdata;
    case (acc_f3)
      F3_B: begin
        acc_be    = 4'b0001 << acc_addr[1:0];
        ram_wdata = {4{acc_wdata[7:0]}};
      end
      F3_H: begin
        acc_be    = acc_addr[1] ? 4'b1100 : 4'b0011;
        ram_wdata = {2{acc_wdata[15:0]}};
      end
      F3_W:    acc_be = 4'b1111;
      default: acc_be = 4'b0000;
    endcase
    ram_we = (acc_en && acc_we && !acc_fault) ? acc_be : 4'b0000;
  end

  dmem_lane_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .en    (acc_en),
    .we    (ram_we),
    .addr  (acc_addr[ADDR_WIDTH+1:2]),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // ---- stage p1: access attributes held for the response cycle
  always_ff @(posedge clk) begin
    if (acc_en) begin
      fault_p1 <= acc_fault;
      we_p1    <= acc_we;
      off_p1   <= acc_addr[1:0];
      f3_p1    <= acc_f3;
    end
  end

  // State and wait counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: accept from IDLE/RESP, count down in WAIT.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE, S_RESP: begin
        if (accept) begin
          if (ZERO_WAIT) begin
            state_nxt = S_RESP;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = 4'(WAIT_CYCLES);
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = S_RESP;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Response outputs, valid only in RESP; rdata zero for stores and faults.
  always_comb begin
    vld_p1    = !rst && (state == S_RESP);
    rsp_valid = vld_p1;
    rsp_fault = vld_p1 && fault_p1;
    rsp_rdata = 32'd0;
    if (vld_p1 && !we_p1 && !fault_p1)
      rsp_rdata = load_extend(ram_rdata, off_p1, f3_p1);
  end

endmodule

// File: tb/tb_dmem_bytelane.sv
// Bench for dmem_bytelane: one zero-wait and one two-wait instance driven
// by directed and random accesses, checked against a byte-array model.
module tb_dmem_bytelane;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        v0, we0, rdy0, rv0, rf0;
  logic [2:0]  f30;
  logic [31:0] a0, wd0, rd0;
  logic        v2, we2, rdy2, rv2, rf2;
  logic [2:0]  f32;
  logic [31:0] a2, wd2, rd2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
  } op_t;

  logic [7:0] mm [bit [32:0]];

  dmem_bytelane #(.ADDR_WIDTH(15), .WAIT_CYCLES(0), .INIT_FILE("")) u0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0), .req_we(we0),
    .req_funct3(f30), .req_addr(a0), .req_wdata(wd0),
    .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_fault(rf0));

  dmem_bytelane #(.ADDR_WIDTH(15), .WAIT_CYCLES(2), .INIT_FILE("")) u2 (
    .clk(clk), .rst(rst), .req_valid(v2), .req_ready(rdy2), .req_we(we2),
    .req_funct3(f32), .req_addr(a2), .req_wdata(wd2),
    .rsp_valid(rv2), .rsp_rdata(rd2), .rsp_fault(rf2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: bytes of the access read or written directly from the byte array.
  function automatic void model_exec(input int inst, input logic we, input logic [2:0] f3,
                                     input logic [31:0] addr, input logic [31:0] wd,
                                     output logic [31:0] rd, output logic flt);
    int n;
    logic [31:0] val;
    bit [32:0] key;
    n   = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    flt = 1'b0;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) flt = 1'b1;
    if (we && f3 >= 3'd4) flt = 1'b1;
    if (n > 1 && (addr % n) != 0) flt = 1'b1;
    if (addr >= 32'h0002_0000) flt = 1'b1;
    rd = 32'd0;
    if (flt) return;
    val = 32'd0;
    for (int b = 0; b < n; b++) begin
      key = {inst == 2, addr + 32'(b)};
      if (we) mm[key] = wd[8*b +: 8];
      else    val = val | (32'(mm[key]) << (8 * b));
    end
    if (!we) begin
      if (f3 == 3'd0 && val[7])  val = val | 32'hFFFF_FF00;
      if (f3 == 3'd1 && val[15]) val = val | 32'hFFFF_0000;
      rd = val;
    end
  endfunction

  // One request, waits for its response; called and returning at a negedge.
  task automatic issue(input int inst, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] obs);
    logic [31:0] exp_rd;
    logic        exp_f;
    int          w, lat, lim;
    model_exec(inst, we, f3, addr, wd, exp_rd, exp_f);
    lim = (inst == 2) ? 3 : 1;
    if (inst == 2) begin v2 = 1; we2 = we; f32 = f3; a2 = addr; wd2 = wd; end
    else           begin v0 = 1; we0 = we; f30 = f3; a0 = addr; wd0 = wd; end
    w = 0;
    while (!((inst == 2) ? rdy2 : rdy0) && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    v0 = 0;
    v2 = 0;
    lat = 21;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if ((inst == 2) ? rv2 : rv0) begin
        lat = k;
        break;
      end
      check("ready_low_in_wait", 32'((inst == 2) ? rdy2 : rdy0), 32'd0);
    end
    check("latency", 32'(lat), 32'(lim));
    obs = (inst == 2) ? rd2 : rd0;
    check("rdata_model", obs, exp_rd);
    check("fault_model", 32'((inst == 2) ? rf2 : rf0), 32'(exp_f));
    @(negedge clk);
    check("valid_one_cycle", 32'((inst == 2) ? rv2 : rv0), 32'd0);
  endtask

  // Back-to-back requests on the zero-wait instance, one response per cycle.
  task automatic burst0(input op_t ops[$]);
    logic [31:0] exp_rd;
    logic        exp_f;
    for (int i = 0; i < ops.size(); i++) begin
      if (i == 0) begin
        v0 = 1; we0 = ops[0].we; f30 = ops[0].f3; a0 = ops[0].addr; wd0 = ops[0].wd;
      end
      model_exec(0, ops[i].we, ops[i].f3, ops[i].addr, ops[i].wd, exp_rd, exp_f);
      @(negedge clk);
      check("burst_valid", 32'(rv0), 32'd1);
      check("burst_rdata", rd0, exp_rd);
      check("burst_fault", 32'(rf0), 32'(exp_f));
      if (i + 1 < ops.size()) begin
        we0 = ops[i+1].we; f30 = ops[i+1].f3; a0 = ops[i+1].addr; wd0 = ops[i+1].wd;
      end else begin
        v0 = 0;
      end
    end
    @(negedge clk);
    check("burst_end_valid", 32'(rv0), 32'd0);
  endtask

  initial begin
    logic [31:0] obs;
    op_t q[$];
    logic        rw;
    logic [2:0]  rf3;
    logic [31:0] raddr;
    rst = 1;
    v0 = 0; we0 = 0; f30 = 0; a0 = 0; wd0 = 0;
    v2 = 0; we2 = 0; f32 = 0; a2 = 0; wd2 = 0;
    repeat (3) @(negedge clk);
    check("rst_ready0", 32'(rdy0), 32'd0);
    check("rst_ready2", 32'(rdy2), 32'd0);
    check("rst_valid0", 32'(rv0), 32'd0);
    check("rst_rdata0", rd0, 32'd0);
    check("rst_fault0", 32'(rf0), 32'd0);
    rst = 0;
    @(negedge clk);
    check("idle_ready0", 32'(rdy0), 32'd1);

    // Word store/load and extensions
    issue(0, 1, 3'd2, 32'h1000, 32'hDEADBEEF, obs);
    check("sw_rdata_zero", obs, 32'd0);
    issue(0, 0, 3'd2, 32'h1000, 32'd0, obs);  check("lw", obs, 32'hDEADBEEF);
    issue(0, 0, 3'd0, 32'h1003, 32'd0, obs);  check("lb", obs, 32'hFFFFFFDE);
    issue(0, 0, 3'd4, 32'h1003, 32'd0, obs);  check("lbu", obs, 32'h000000DE);
    issue(0, 0, 3'd1, 32'h1002, 32'd0, obs);  check("lh", obs, 32'hFFFFDEAD);
    issue(0, 0, 3'd5, 32'h1000, 32'd0, obs);  check("lhu", obs, 32'h0000BEEF);

    // Partial stores
    issue(0, 1, 3'd0, 32'h1001, 32'h00000055, obs);
    issue(0, 0, 3'd2, 32'h1000, 32'd0, obs);  check("sb_then_lw", obs, 32'hDEAD55EF);
    issue(0, 1, 3'd1, 32'h1002, 32'h00001234, obs);
    issue(0, 0, 3'd2, 32'h1000, 32'd0, obs);  check("sh_then_lw", obs, 32'h123455EF);

    // Faults
    issue(0, 0, 3'd2, 32'h1002, 32'd0, obs);  check("lw_misaligned", obs, 32'd0);
    check("lw_misaligned_fault", 32'(rf0), 32'd0);
    issue(0, 1, 3'd1, 32'h1001, 32'h0000FFFF, obs);
    issue(0, 0, 3'd2, 32'h1000, 32'd0, obs);  check("after_bad_sh", obs, 32'h123455EF);
    issue(0, 0, 3'd2, 32'h0002_0000, 32'd0, obs); check("lw_range", obs, 32'd0);
    issue(0, 0, 3'd3, 32'h1000, 32'd0, obs);  check("f3_011", obs, 32'd0);
    issue(0, 1, 3'd4, 32'h1000, 32'h0, obs);
    issue(0, 0, 3'd2, 32'h1000, 32'd0, obs);  check("after_bad_sbu", obs, 32'h123455EF);

    // Back-to-back loads and store-then-load to the same word
    q = {};
    for (int i = 0; i < 4; i++) q.push_back('{1'b1, 3'd2, 32'h3000 + 32'(4*i), $urandom});
    burst0(q);
    q = {};
    for (int i = 0; i < 4; i++) q.push_back('{1'b0, 3'd2, 32'h3000 + 32'(4*i), 32'd0});
    q.push_back('{1'b1, 3'd2, 32'h3004, 32'hA5A5_0F0F});
    q.push_back('{1'b0, 3'd2, 32'h3004, 32'd0});
    q.push_back('{1'b1, 3'd0, 32'h3006, 32'h0000_0081});
    q.push_back('{1'b0, 3'd1, 32'h3006, 32'd0});
    burst0(q);

    // Wait-state instance: prior contents, then a store dropped by reset
    issue(2, 1, 3'd2, 32'h2000, 32'h11223344, obs);
    issue(2, 0, 3'd2, 32'h2000, 32'd0, obs);  check("w2_lw", obs, 32'h11223344);
    v2 = 1; we2 = 1; f32 = 3'd2; a2 = 32'h2000; wd2 = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    v2 = 0;
    @(negedge clk);
    check("w2_ready_in_wait", 32'(rdy2), 32'd0);
    rst = 1;
    #1;
    check("rst_mid_ready2", 32'(rdy2), 32'd0);
    check("rst_mid_ready0", 32'(rdy0), 32'd0);
    @(negedge clk);
    rst = 0;
    for (int k = 0; k < 5; k++) begin
      check("no_rsp_after_rst", 32'(rv2), 32'd0);
      @(negedge clk);
    end
    issue(2, 0, 3'd2, 32'h2000, 32'd0, obs);  check("w2_after_rst", obs, 32'h11223344);

    // Random traffic over a prewritten region on both instances
    for (int i = 0; i < 16; i++) begin
      issue(0, 1, 3'd2, 32'h3000 + 32'(4*i), $urandom, obs);
      issue(2, 1, 3'd2, 32'h3000 + 32'(4*i), $urandom, obs);
    end
    for (int i = 0; i < 60; i++) begin
      rw    = 1'($urandom_range(0, 1));
      rf3   = 3'($urandom_range(0, 7));
      raddr = 32'h3000 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) raddr = raddr | 32'h0002_0000;
      issue((i % 3 == 0) ? 2 : 0, rw, rf3, raddr, $urandom, obs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
